// File: rtl/clcd_text_buffer_if.sv
// clcd_text_buffer_if: application-side write/cursor/clear port of the LCD text buffer
// master: drives wr_valid, wr_char, pos_set, pos_val, clr_req; sees wr_ready, clr_busy, cursor
// slave : the buffer, the opposite directions
interface clcd_text_buffer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_char;
  logic       pos_set;
  logic [4:0] pos_val;
  logic       clr_req;
  logic       clr_busy;
  logic [4:0] cursor;
  modport master(output wr_valid, wr_char, pos_set, pos_val, clr_req, input wr_ready, clr_busy, cursor);
  modport slave(input wr_valid, wr_char, pos_set, pos_val, clr_req, output wr_ready, clr_busy, cursor);
endinterface

// File: rtl/clcd_text_buffer.sv
// clcd_text_buffer: double-buffered 2x16 text store feeding the LCD controller
// Ports: clk, reset (sync, active-high); wr (clcd_text_buffer_if.slave) cursor-based write port;
//        frame_start (copy back->front when dirty), rd_addr/rd_data (registered front read), dirty.
// Option: define CLCD_ASCII_FILTER_EN to store non-printable, non-control codes as '?'.
module clcd_text_buffer #(
  parameter logic [7:0] FILL_CHAR  = 8'h20,
  parameter int         CLR_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  clcd_text_buffer_if.slave    wr,
  input  logic                 frame_start,
  input  logic [4:0]           rd_addr,
  output logic [7:0]           rd_data,
  output logic                 dirty
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t     state, state_nx;
  logic [7:0] back [32];
  logic [7:0] front [32];
  logic [4:0] cursor, cursor_nx, idx, store_addr;
  logic [7:0] store_char;
  logic       busy, last, done, accept, copy, store;
  assign busy        = state == CLEAR;
  assign last        = idx == 5'(CLR_CYCLES - 1);
  assign done        = busy && last;
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign copy        = frame_start && dirty && !busy;
  assign wr.clr_busy = busy;
  assign wr.wr_ready = !busy && !wr.pos_set;
  assign wr.cursor   = cursor;
  always_comb begin
    state_nx = busy ? (last ? IDLE : CLEAR) : (wr.clr_req ? CLEAR : IDLE);
  end
  always_comb begin
    store      = 1'b0;
    store_addr = cursor;
    store_char = wr.wr_char;
    cursor_nx  = cursor;
    if (done) cursor_nx = '0;
    else if (!busy && wr.pos_set) cursor_nx = wr.pos_val;
    else if (accept) begin
      if (wr.wr_char == 8'h0A) cursor_nx = {~cursor[4], 4'd0};
      else if (wr.wr_char == 8'h0D) cursor_nx = {cursor[4], 4'd0};
      else if (wr.wr_char == 8'h08) begin
        store      = cursor != '0;
        store_addr = cursor - 5'd1;
        store_char = FILL_CHAR;
        cursor_nx  = cursor != '0 ? cursor - 5'd1 : cursor;
      end else begin
        store     = 1'b1;
        cursor_nx = cursor + 5'd1;
`ifdef CLCD_ASCII_FILTER_EN
        if (wr.wr_char < 8'h20 || wr.wr_char > 8'h7E) store_char = 8'h3F;
`endif
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      cursor  <= '0;
      dirty   <= 1'b0;
      rd_data <= FILL_CHAR;
      for (int i = 0; i < 32; i++) begin
        back[i]  <= FILL_CHAR;
        front[i] <= FILL_CHAR;
      end
    end else begin
      state   <= state_nx;
      idx     <= busy ? idx + 5'd1 : '0;
      cursor  <= cursor_nx;
      rd_data <= front[rd_addr];
      dirty   <= done || store || (dirty && !copy);
      // the last sweep cycle also fills every position the shortened sweep never reached
      for (int i = 0; i < 32; i++) begin
        if (copy) front[i] <= back[i];
        if (busy && (5'(i) == idx || (last && 5'(i) > idx))) back[i] <= FILL_CHAR;
      end
      if (store) back[store_addr] <= store_char;
    end
  end
endmodule
